// File: rtl/instr_fetch.sv
// Instruction fetch: issues reads to a synchronous instruction memory, captures the
// returned word and hands {pc, instr} to decode. Optional range check: FETCH_RANGE_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h01000000,
  parameter logic [31:0] IMEM_BASE  = 32'h01000000,
  parameter logic [31:0] IMEM_LIMIT = 32'h010007FC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  logic [31:0] pc_reg;
  logic        inflight_reg;
  logic [31:0] inflight_pc_reg;
  logic        kill_reg;
  logic [1:0]  count_reg;
  logic [31:0] out_pc_reg;
  logic [31:0] out_instr_reg;
  logic [31:0] skid_pc_reg;
  logic [31:0] skid_instr_reg;
  logic        fault_reg;

  logic        pop;
  logic        push;
  logic        can_issue;
  logic        issue;
  logic        fault_set;
  logic [2:0]  pending;

  assign pop       = out_valid && out_ready;
  assign push      = inflight_reg && !kill_reg;
  // Words already buffered plus the one returning now, minus the one leaving:
  // issuing only below two guarantees a free slot when the new word lands.
  assign pending   = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign can_issue = !rst && !redirect_valid && (pending < 3'd2);

`ifdef FETCH_RANGE_CHECK_EN
  logic in_range;
  assign in_range    = (pc_reg >= IMEM_BASE) && (pc_reg <= IMEM_LIMIT);
  assign issue       = can_issue && in_range;
  assign fetch_fault = fault_reg;
`else
  assign issue       = can_issue;
  // Range parameters stay referenced even though checking is compiled out.
  assign fetch_fault = fault_reg & (IMEM_BASE <= IMEM_LIMIT);
`endif
  assign fault_set = can_issue && !issue;

  assign imem_rd   = issue;
  assign imem_addr = rst ? RESET_PC : pc_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_pc    = out_pc_reg;
  assign out_instr = out_instr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0;
      kill_reg        <= 1'b0;
      count_reg       <= 2'd0;
      out_pc_reg      <= 32'h0;
      out_instr_reg   <= 32'h0;
      skid_pc_reg     <= 32'h0;
      skid_instr_reg  <= 32'h0;
      fault_reg       <= 1'b0;
    end else if (redirect_valid) begin
      // Flush everything; a response arriving this cycle is dropped with the FIFO.
      pc_reg       <= redirect_pc & ~32'h3;
      kill_reg     <= inflight_reg;
      inflight_reg <= 1'b0;
      count_reg    <= 2'd0;
      fault_reg    <= 1'b0;
    end else begin
      kill_reg <= 1'b0;
      if (issue) begin
        pc_reg          <= pc_reg + 32'd4;
        inflight_reg    <= 1'b1;
        inflight_pc_reg <= pc_reg;
      end else begin
        inflight_reg <= 1'b0;
      end
      if (fault_set) begin
        fault_reg <= 1'b1;
      end
      // Output register is the FIFO head and only loads when a new head arrives,
      // so out_pc/out_instr hold while nothing valid is presented.
      case (count_reg)
        2'd0: begin
          if (push) begin
            out_pc_reg    <= inflight_pc_reg;
            out_instr_reg <= imem_instr;
            count_reg     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            out_pc_reg    <= inflight_pc_reg;
            out_instr_reg <= imem_instr;
          end else if (push) begin
            skid_pc_reg    <= inflight_pc_reg;
            skid_instr_reg <= imem_instr;
            count_reg      <= 2'd2;
          end else if (pop) begin
            count_reg <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            out_pc_reg    <= skid_pc_reg;
            out_instr_reg <= skid_instr_reg;
            if (push) begin
              skid_pc_reg    <= inflight_pc_reg;
              skid_instr_reg <= imem_instr;
            end else begin
              count_reg <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand-written
// redirect/wrap (or range-fault when FETCH_RANGE_CHECK_EN) sequences.
module tb_instr_fetch;

  localparam logic [31:0] B = 32'h01000000;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  int compared = 0;
  int mismatched = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
  endfunction

  // Synchronous memory; garbage when not read so stray sampling is visible.
  always @(posedge clk) imem_instr <= imem_rd ? mem_word(imem_addr) : 32'hBAD0BAD0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic erd, input logic [31:0] eaddr, input logic ev, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_rd = erd; v.e_addr = eaddr; v.e_valid = ev; v.e_pc = epc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
  endtask

  int lat;

  initial begin
    // Stream from reset, always ready
    add(L, L, 0, H,  H, B+32'h000, L, 0);
    add(L, L, 0, H,  H, B+32'h004, L, 0);
    add(L, L, 0, H,  H, B+32'h008, H, B+32'h000);
    add(L, L, 0, H,  H, B+32'h00C, H, B+32'h004);
    // Back-pressure: buffer fills, reads stop, nothing lost
    add(L, L, 0, L,  L, B+32'h010, H, B+32'h008);
    add(L, L, 0, L,  L, B+32'h010, H, B+32'h008);
    add(L, L, 0, L,  L, B+32'h010, H, B+32'h008);
    add(L, L, 0, H,  H, B+32'h010, H, B+32'h008);
    add(L, L, 0, H,  H, B+32'h014, H, B+32'h00C);
    add(L, L, 0, H,  H, B+32'h018, H, B+32'h010);
    // Misaligned redirect with a word buffered and one returning
    add(L, H, B+32'h103, L,  L, B+32'h01C, H, B+32'h014);
    add(L, L, 0, H,  H, B+32'h100, L, 0);
    add(L, L, 0, H,  H, B+32'h104, L, 0);
    add(L, L, 0, H,  H, B+32'h108, H, B+32'h100);
    // Back-to-back redirects; handshake on the first still completes
    add(L, H, B+32'h040, H,  L, B+32'h10C, H, B+32'h104);
    add(L, H, B+32'h080, H,  L, B+32'h040, L, 0);
    add(L, L, 0, H,  H, B+32'h080, L, 0);
    add(L, L, 0, H,  H, B+32'h084, L, 0);
    add(L, L, 0, H,  H, B+32'h088, H, B+32'h080);
    add(L, L, 0, H,  H, B+32'h08C, H, B+32'h084);
    // Fill to two, then reset mid-stream
    add(L, L, 0, L,  L, B+32'h090, H, B+32'h088);
    add(L, L, 0, L,  L, B+32'h090, H, B+32'h088);
    add(H, L, 0, L,  L, B+32'h000, H, B+32'h088);
    add(H, L, 0, L,  L, B+32'h000, L, 0);
    add(L, L, 0, H,  H, B+32'h000, L, 0);
    add(L, L, 0, H,  H, B+32'h004, L, 0);
    add(L, L, 0, H,  H, B+32'h008, H, B+32'h000);

    drive(H, L, 0, L);
    drive(H, L, 0, L);
    chk("reset_rd", {31'b0, imem_rd}, 0);
    chk("reset_addr", imem_addr, B);
    chk("reset_valid", {31'b0, out_valid}, 0);
    chk("reset_pc", out_pc, 0);
    chk("reset_instr", out_instr, 0);
    chk("reset_fault", {31'b0, fetch_fault}, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      $display("cyc %0d rst=%0b redir=%0b rdy=%0b rd=%0b addr=%h valid=%0b pc=%h instr=%h",
               i, rst, redirect_valid, out_ready, imem_rd, imem_addr, out_valid, out_pc, out_instr);
      chk($sformatf("v%0d_rd", i), {31'b0, imem_rd}, {31'b0, vecs[i].e_rd});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_fault", i), {31'b0, fetch_fault}, 0);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_instr", i), out_instr, mem_word(vecs[i].e_pc));
      end
    end

`ifdef FETCH_RANGE_CHECK_EN
    // Last legal word is delivered, then the next sequential PC faults.
    drive(L, H, B+32'h7FC, H);
    lat = 99;
    for (int i = 0; i < 8; i++) begin
      drive(L, L, 0, H);
      if (out_valid) begin lat = i; break; end
    end
    chk("lim_latency", lat, 2);
    chk("lim_pc", out_pc, B+32'h7FC);
    chk("lim_instr", out_instr, mem_word(B+32'h7FC));
    chk("lim_fault", {31'b0, fetch_fault}, 1);
    chk("lim_rd", {31'b0, imem_rd}, 0);
    drive(L, L, 0, H);
    chk("lim_drained", {31'b0, out_valid}, 0);
    chk("lim_sticky", {31'b0, fetch_fault}, 1);
    chk("lim_rd2", {31'b0, imem_rd}, 0);
    drive(L, H, B, H);
    drive(L, L, 0, H);
    chk("clr_fault", {31'b0, fetch_fault}, 0);
    chk("clr_rd", {31'b0, imem_rd}, 1);
    chk("clr_addr", imem_addr, B);
    lat = 99;
    for (int i = 0; i < 8; i++) begin
      drive(L, L, 0, H);
      if (out_valid) begin lat = i; break; end
    end
    chk("clr_latency", lat, 1);
    chk("clr_pc", out_pc, B);
`else
    // Address wraps from the top of the space to zero.
    drive(L, H, 32'hFFFFFFFC, H);
    lat = 99;
    for (int i = 0; i < 8; i++) begin
      drive(L, L, 0, H);
      if (out_valid) begin lat = i; break; end
    end
    chk("wrap_latency", lat, 2);
    chk("wrap_pc0", out_pc, 32'hFFFFFFFC);
    chk("wrap_instr0", out_instr, mem_word(32'hFFFFFFFC));
    drive(L, L, 0, H);
    chk("wrap_valid1", {31'b0, out_valid}, 1);
    chk("wrap_pc1", out_pc, 32'h0);
    chk("wrap_instr1", out_instr, mem_word(32'h0));
    chk("wrap_fault", {31'b0, fetch_fault}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
